// File: rtl/bsg_fifo_bypass.sv
// Ready/valid FIFO of els_p entries; when empty and bypass_p=1 the input word
// reaches the output in the same cycle, otherwise words drain in arrival order.
module bsg_fifo_bypass #(
    parameter int width_p  = 16,
    parameter int els_p    = 4,
    parameter int bypass_p = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       ready_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       yumi_i,
    output logic [$clog2(els_p+1)-1:0] count_o
);
    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);
    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(els_p - 1);
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(els_p);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   wptr;
    logic [ptr_w-1:0]   rptr;
    logic [cnt_w-1:0]   count;
    logic               empty;
    logic               enq;
    logic               bypass_consume;
    logic               do_write;
    logic               do_read;

    assign empty   = (count == '0);
    assign ready_o = (count != full_cnt);
    assign count_o = count;
    assign enq     = v_i & ready_o;

    // A word taken straight through never touches storage or pointers.
    assign bypass_consume = (bypass_p != 0) && empty && v_i && yumi_i;
    assign do_write       = enq & ~bypass_consume;
    assign do_read        = yumi_i & ~empty;

    generate
        if (bypass_p != 0) begin : g_bypass
            assign v_o    = empty ? v_i : 1'b1;
            assign data_o = empty ? data_i : mem[rptr];
        end else begin : g_registered
            assign v_o    = ~empty;
            assign data_o = mem[rptr];
        end
    endgenerate

    // Explicit wrap keeps non-power-of-two depths inside the array.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_write) begin
                wptr <= (wptr == last_ptr) ? '0 : wptr + 1'b1;
            end
            if (do_read) begin
                rptr <= (rptr == last_ptr) ? '0 : rptr + 1'b1;
            end
            if (do_write && !do_read) begin
                count <= count + 1'b1;
            end else if (do_read && !do_write) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem[wptr] <= data_i;
        end
    end

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_fifo_bypass.sv
// Directed bench for bsg_fifo_bypass: bypass (depth 4), wrap (depth 3) and
// registered (bypass off) instances sharing one clock and reset.
module tb_bsg_fifo_bypass;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    logic        b_v = 1'b0, b_yumi = 1'b0, b_ready, b_vo;
    logic [15:0] b_data = '0, b_data_o;
    logic [2:0]  b_count;

    logic        w_v = 1'b0, w_yumi = 1'b0, w_ready, w_vo;
    logic [15:0] w_data = '0, w_data_o;
    logic [1:0]  w_count;

    logic        r_v = 1'b0, r_yumi = 1'b0, r_ready, r_vo;
    logic [15:0] r_data = '0, r_data_o;
    logic [2:0]  r_count;

    int total = 0;
    int bad = 0;

    bsg_fifo_bypass #(.width_p(16), .els_p(4), .bypass_p(1)) u_byp (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(b_v), .data_i(b_data),
        .ready_o(b_ready), .v_o(b_vo), .data_o(b_data_o), .yumi_i(b_yumi),
        .count_o(b_count));

    bsg_fifo_bypass #(.width_p(16), .els_p(3), .bypass_p(1)) u_wrap (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(w_v), .data_i(w_data),
        .ready_o(w_ready), .v_o(w_vo), .data_o(w_data_o), .yumi_i(w_yumi),
        .count_o(w_count));

    bsg_fifo_bypass #(.width_p(16), .els_p(4), .bypass_p(0)) u_reg (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(r_v), .data_i(r_data),
        .ready_o(r_ready), .v_o(r_vo), .data_o(r_data_o), .yumi_i(r_yumi),
        .count_o(r_count));

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nxt, rcv, mcount, cyc;
        logic exp_vo, can_enq;
        logic [15:0] exp_word;

        #3;
        checkOutput("rst_ready", {31'd0, r_ready}, 32'd1);
        checkOutput("rst_count", {29'd0, r_count}, 32'd0);
        checkOutput("rst_vo_reg", {31'd0, r_vo}, 32'd0);
        checkOutput("rst_vo_byp", {31'd0, b_vo}, 32'd0);
        #9 reset_n = 1'b1;
        tick();

        // Same-cycle bypass on an empty FIFO
        b_v = 1'b1; b_data = 16'hA5A5; b_yumi = 1'b1;
        #1;
        checkOutput("byp_vo", {31'd0, b_vo}, 32'd1);
        checkOutput("byp_data", {16'd0, b_data_o}, 32'hA5A5);
        tick();
        b_v = 1'b0; b_yumi = 1'b0;
        checkOutput("byp_count", {29'd0, b_count}, 32'd0);

        // Fill and stall
        for (int k = 1; k <= 4; k++) begin
            b_v = 1'b1; b_data = 16'(k);
            tick();
        end
        checkOutput("fill_count", {29'd0, b_count}, 32'd4);
        checkOutput("fill_ready", {31'd0, b_ready}, 32'd0);
        b_data = 16'd5;
        tick();
        b_v = 1'b0;
        checkOutput("full_count", {29'd0, b_count}, 32'd4);
        for (int k = 1; k <= 4; k++) begin
            #1;
            checkOutput("drain_vo", {31'd0, b_vo}, 32'd1);
            checkOutput("drain_data", {16'd0, b_data_o}, 32'(k));
            b_yumi = 1'b1;
            tick();
            if (k == 1) begin
                checkOutput("drain_ready", {31'd0, b_ready}, 32'd1);
                checkOutput("drain_count", {29'd0, b_count}, 32'd3);
            end
        end
        b_yumi = 1'b0;
        checkOutput("drain_empty", {29'd0, b_count}, 32'd0);

        // Depth-3 stream with irregular producer and consumer
        nxt = 0; rcv = 0; mcount = 0; cyc = 0;
        while (rcv < 10 && cyc < 200) begin
            w_v = (nxt < 10) && (cyc % 3 != 2);
            w_data = 16'(nxt);
            exp_vo = (mcount > 0) || w_v;
            w_yumi = exp_vo && ((cyc % 4) < 2);
            #1;
            checkOutput("wrap_vo", {31'd0, w_vo}, {31'd0, exp_vo});
            checkOutput("wrap_ready", {31'd0, w_ready}, {31'd0, mcount != 3});
            if (w_yumi) begin
                checkOutput("wrap_order", {16'd0, w_data_o}, 32'(rcv));
                rcv++;
            end
            can_enq = (mcount < 3);
            if (mcount == 0 && w_v && w_yumi) begin
                nxt++;
            end else begin
                if (w_yumi) mcount--;
                if (w_v && can_enq) begin
                    nxt++;
                    mcount++;
                end
            end
            tick();
            checkOutput("wrap_count", {30'd0, w_count}, 32'(mcount));
            checkOutput("wrap_le3", {31'd0, w_count <= 2'd3}, 32'd1);
            cyc++;
        end
        w_v = 1'b0; w_yumi = 1'b0;
        checkOutput("wrap_all", 32'(rcv), 32'd10);

        // Registered mode: one cycle latency, then one word per cycle
        r_v = 1'b1; r_data = 16'h1234; r_yumi = 1'b0;
        #1;
        checkOutput("reg_vo0", {31'd0, r_vo}, 32'd0);
        tick();
        checkOutput("reg_count1", {29'd0, r_count}, 32'd1);
        exp_word = 16'h1234;
        for (int k = 0; k < 5; k++) begin
            r_data = 16'h2000 + 16'(k); r_yumi = 1'b1;
            #1;
            checkOutput("reg_vo", {31'd0, r_vo}, 32'd1);
            checkOutput("reg_data", {16'd0, r_data_o}, {16'd0, exp_word});
            tick();
            checkOutput("reg_stream_cnt", {29'd0, r_count}, 32'd1);
            exp_word = 16'h2000 + 16'(k);
        end
        r_v = 1'b0;
        #1;
        checkOutput("reg_last", {16'd0, r_data_o}, 32'h2004);
        tick();
        r_yumi = 1'b0;
        checkOutput("reg_empty", {29'd0, r_count}, 32'd0);

        // Reset while holding three words
        for (int k = 0; k < 3; k++) begin
            r_v = 1'b1; r_data = 16'h000A + 16'(k);
            tick();
        end
        r_v = 1'b0;
        checkOutput("mid_count3", {29'd0, r_count}, 32'd3);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid_count", {29'd0, r_count}, 32'd0);
        checkOutput("mid_ready", {31'd0, r_ready}, 32'd1);
        checkOutput("mid_vo", {31'd0, r_vo}, 32'd0);
        #1 reset_n = 1'b1;
        r_v = 1'b1; r_data = 16'h5555;
        tick();
        r_v = 1'b0;
        checkOutput("post_vo", {31'd0, r_vo}, 32'd1);
        checkOutput("post_data", {16'd0, r_data_o}, 32'h5555);
        checkOutput("post_count", {29'd0, r_count}, 32'd1);
        r_yumi = 1'b1;
        tick();
        r_yumi = 1'b0;
        checkOutput("post_drain", {29'd0, r_count}, 32'd0);
        checkOutput("post_vo0", {31'd0, r_vo}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
